// File: rtl/xosera_bus_host_pkg.sv
// Shared Xosera bus definitions: strobe/direction levels, FSM states and
// the latched request record used by the host-side bus initiator.
package xosera_bus_host_pkg;

    localparam logic cs_ENABLED  = 1'b0;
    localparam logic cs_DISABLED = 1'b1;
    localparam logic RnW_READ    = 1'b1;
    localparam logic RnW_WRITE   = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } bus_state_t;

    typedef struct packed {
        logic        rd_nwr;
        logic [3:0]  reg_num;
        logic [1:0]  bytes;    // bit1 = even/MSB, bit0 = odd/LSB
        logic [15:0] data;     // [15:8] = even byte
    } bus_req_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Odd byte lives in the low half of the 16-bit word.
    function automatic logic [7:0] sel_byte(input logic [15:0] d, input logic odd);
        return odd ? d[7:0] : d[15:8];
    endfunction

endpackage

// File: rtl/xosera_bus_host.sv
// Host-side initiator for the Xosera 8-bit register bus. Splits a 16-bit
// register access into one or two byte strobes, even byte first.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | ready for a request, bus quiet
//  SETUP  | address/control/write data driven, cs_n high
//  STROBE | cs_n low; read data captured on the last cycle's edge
//  HOLD   | cs_n high, address/data held
//  DONE   | one-cycle response pulse; not ready, gives bus turnaround
module xosera_bus_host
    import xosera_bus_host_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rd_nwr_i,
    input  logic [3:0]  req_reg_num_i,
    input  logic [1:0]  req_bytes_i,
    input  logic [15:0] req_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        busy_o,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic        bus_bytesel_o,
    output logic [3:0]  bus_reg_num_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe_o,
    input  logic [7:0]  bus_data_i
);

    localparam int MAX_CYC = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    bus_state_t    r_state;
    bus_state_t    w_state_next;
    bus_req_t      r_req;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_init;
    logic          r_second;
    logic [15:0]   r_acc;

    logic          r_cs_n;
    logic          r_rd_nwr;
    logic          r_bytesel;
    logic [3:0]    r_reg_num;
    logic [7:0]    r_data_o;
    logic          r_oe;
    logic          r_rsp_valid;
    logic          r_busy;

    logic          w_accept;
    logic          w_tc;
    logic          w_more;
    logic          w_setup_to_strobe;
    logic          w_strobe_to_hold;
    logic          w_hold_to_setup;
    logic          w_enter_done;

    // Next-state decode and the reload value for the shared down-counter.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cnt_init   = '0;
        w_tc         = (r_cnt == '0);
        w_more       = (r_req.bytes == 2'b11) && !r_second;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = (req_bytes_i == 2'b00) ? DONE : SETUP;
                end
            end
            SETUP:   if (w_tc) w_state_next = STROBE;
            STROBE:  if (w_tc) w_state_next = HOLD;
            HOLD:    if (w_tc) w_state_next = w_more ? SETUP : DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        case (w_state_next)
            SETUP:   w_cnt_init = CW'(SETUP_CYCLES - 1);
            STROBE:  w_cnt_init = CW'(STROBE_CYCLES - 1);
            HOLD:    w_cnt_init = CW'(HOLD_CYCLES - 1);
            default: w_cnt_init = '0;
        endcase
    end

    assign w_setup_to_strobe = (r_state == SETUP)  && (w_state_next == STROBE);
    assign w_strobe_to_hold  = (r_state == STROBE) && (w_state_next == HOLD);
    assign w_hold_to_setup   = (r_state == HOLD)   && (w_state_next == SETUP);
    assign w_enter_done      = (r_state != DONE)   && (w_state_next == DONE);

    // State register and per-state down-counter (reloaded on every state change).
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_cnt <= w_cnt_init;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Request latch, read accumulator and registered bus outputs.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_req       <= '0;
            r_second    <= 1'b0;
            r_acc       <= '0;
            r_cs_n      <= cs_DISABLED;
            r_rd_nwr    <= RnW_READ;
            r_bytesel   <= 1'b0;
            r_reg_num   <= '0;
            r_data_o    <= '0;
            r_oe        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_req    <= {req_rd_nwr_i, req_reg_num_i, req_bytes_i, req_data_i};
                r_second <= 1'b0;
                r_acc    <= '0;
                r_busy   <= 1'b1;
                // A zero-byte request never touches the bus lines.
                if (req_bytes_i != 2'b00) begin
                    r_rd_nwr  <= req_rd_nwr_i;
                    r_reg_num <= req_reg_num_i;
                    r_bytesel <= !req_bytes_i[1];
                    r_data_o  <= sel_byte(req_data_i, !req_bytes_i[1]);
                    r_oe      <= (req_rd_nwr_i == RnW_WRITE);
                end
            end
            if (w_setup_to_strobe) begin
                r_cs_n <= cs_ENABLED;
            end
            if (w_strobe_to_hold) begin
                r_cs_n <= cs_DISABLED;
                if (r_req.rd_nwr == RnW_READ) begin
                    if (r_bytesel) begin
                        r_acc[7:0]  <= bus_data_i;
                    end else begin
                        r_acc[15:8] <= bus_data_i;
                    end
                end
            end
            // Second byte is always the odd one; oe stays up across the gap.
            if (w_hold_to_setup) begin
                r_second  <= 1'b1;
                r_bytesel <= 1'b1;
                r_rd_nwr  <= r_req.rd_nwr;
                r_reg_num <= r_req.reg_num;
                r_data_o  <= sel_byte(r_req.data, 1'b1);
            end
            if (w_enter_done) begin
                r_oe        <= 1'b0;
                r_busy      <= 1'b0;
                r_rsp_valid <= 1'b1;
            end
        end
    end

    assign req_ready_o   = (r_state == IDLE);
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_acc;
    assign busy_o        = r_busy;
    assign bus_cs_n_o    = r_cs_n;
    assign bus_rd_nwr_o  = r_rd_nwr;
    assign bus_bytesel_o = r_bytesel;
    assign bus_reg_num_o = r_reg_num;
    assign bus_data_o    = r_data_o;
    assign bus_data_oe_o = r_oe;

endmodule
